cdb_rr_bus: RTL and testbench

//  Parametrised common data bus: N functional-unit result channels compete for one

---
 rtl/cdb_rr_bus.sv | 117 +++++++++++
 tb/tb_cdb_rr_bus.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cdb_rr_bus.sv
// Common data bus: N result channels compete for one registered broadcast slot per cycle.
// Round-robin (or fixed-priority) arbitration, valid/ready handshake, flush squashes the grant.
module cdb_rr_bus #(
  parameter int N_CH       = 2,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 4,
  parameter bit FIXED_PRIO = 1'b0,
  localparam int SRC_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req_valid,
  output logic [N_CH-1:0]          req_ready,
  input  logic [N_CH*DATA_W-1:0]   req_data,
  input  logic [N_CH*TAG_W-1:0]    req_tag,
  input  logic                     flush,
  output logic                     cdb_valid,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [SRC_W-1:0]         cdb_src
);

  localparam logic [SRC_W:0]   N_CH_EXT = (SRC_W+1)'(N_CH);
  localparam logic [SRC_W-1:0] LAST_CH  = SRC_W'(N_CH - 1);

  // Handshake: a transfer on channel i happens in the cycle where
  // req_valid[i] && req_ready[i]; req_ready is at most one-hot, never set
  // for an invalid channel, and all zero under flush or reset. The requester
  // holds data/tag/valid until ready; nothing rejected is buffered here.

  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

  logic [SRC_W-1:0]  search_start;
  logic [SRC_W:0]    search_sum;
  logic [SRC_W-1:0]  cand;
  logic              found;
  logic [SRC_W-1:0]  grant_idx;
  logic              xfer;
  logic [N_CH-1:0]   grant_oh;

  // Priority search starting at the pointer, wrapping modulo N_CH.
  always_comb begin
    search_start = (FIXED_PRIO) ? '0 : rr_ptr_q;
    search_sum   = '0;
    cand         = '0;
    found        = 1'b0;
    grant_idx    = '0;
    for (int k = 0; k < N_CH; k++) begin
      search_sum = {1'b0, search_start} + (SRC_W+1)'(k);
      if (search_sum >= N_CH_EXT) begin
        search_sum = search_sum - N_CH_EXT;
      end
      cand = search_sum[SRC_W-1:0];
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    xfer     = found && !flush && rst;
    grant_oh = '0;
    if (xfer) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  assign req_ready = grant_oh;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = xfer;
    cdb_data_d  = '0;
    cdb_tag_d   = '0;
    cdb_src_d   = '0;
    if (xfer) begin
      cdb_src_d = grant_idx;
      if (!FIXED_PRIO) begin
        rr_ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + SRC_W'(1);
      end
    end
    // One-hot OR-mux keeps the select free of variable part-selects.
    for (int i = 0; i < N_CH; i++) begin
      if (grant_oh[i]) begin
        cdb_data_d = cdb_data_d | req_data[i*DATA_W +: DATA_W];
        cdb_tag_d  = cdb_tag_d  | req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_tag_q   <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_rr_bus.sv
// Bench for cdb_rr_bus: a round-robin and a fixed-priority instance, 4 channels each,
// driven from shared inputs; directed table plus hand-written reset/fairness/priority runs.
module tb_cdb_rr_bus;

  localparam int N_CH   = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int SRC_W  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N_CH-1:0]        req_valid = '0;
  logic [N_CH*DATA_W-1:0] req_data;
  logic [N_CH*TAG_W-1:0]  req_tag;
  logic                   flush = 1'b0;

  logic [N_CH-1:0]   rr_ready,  fp_ready;
  logic              rr_cv,     fp_cv;
  logic [DATA_W-1:0] rr_data,   fp_data;
  logic [TAG_W-1:0]  rr_tag,    fp_tag;
  logic [SRC_W-1:0]  rr_src,    fp_src;

  cdb_rr_bus #(.N_CH(N_CH), .DATA_W(DATA_W), .TAG_W(TAG_W), .FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr_ready),
    .req_data(req_data), .req_tag(req_tag), .flush(flush),
    .cdb_valid(rr_cv), .cdb_data(rr_data), .cdb_tag(rr_tag), .cdb_src(rr_src)
  );

  cdb_rr_bus #(.N_CH(N_CH), .DATA_W(DATA_W), .TAG_W(TAG_W), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(fp_ready),
    .req_data(req_data), .req_tag(req_tag), .flush(flush),
    .cdb_valid(fp_cv), .cdb_data(fp_data), .cdb_tag(fp_tag), .cdb_src(fp_src)
  );

  // Fixed per-channel payloads: ch0 carries tag 0 and ch2 the DEADBEEF/5 pair.
  localparam logic [DATA_W-1:0] D0 = 32'h0A0A_0A0A, D1 = 32'h1111_1111,
                                D2 = 32'hDEAD_BEEF, D3 = 32'h3333_3333;
  localparam logic [TAG_W-1:0]  T0 = 4'h0, T1 = 4'h3, T2 = 4'h5, T3 = 4'hF;
  assign req_data = {D3, D2, D1, D0};
  assign req_tag  = {T3, T2, T1, T0};

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_cdb(input string pfx, input logic cv, input logic [SRC_W-1:0] src,
                            input logic [DATA_W-1:0] data, input logic [TAG_W-1:0] tag,
                            input logic a_cv, input logic [SRC_W-1:0] a_src,
                            input logic [DATA_W-1:0] a_data, input logic [TAG_W-1:0] a_tag);
    exp_q.push_back(32'(cv));   chk({pfx, " cdb_valid"}, 32'(a_cv));
    exp_q.push_back(32'(src));  chk({pfx, " cdb_src"},   32'(a_src));
    exp_q.push_back(data);      chk({pfx, " cdb_data"},  a_data);
    exp_q.push_back(32'(tag));  chk({pfx, " cdb_tag"},   32'(a_tag));
  endtask

  typedef struct {
    logic [N_CH-1:0]   valid;
    logic              flush;
    logic [N_CH-1:0]   exp_ready;
    logic              exp_cv;
    logic [SRC_W-1:0]  exp_src;
    logic [DATA_W-1:0] exp_data;
    logic [TAG_W-1:0]  exp_tag;
  } vec_t;

  vec_t vecs[19];

  initial begin
    // table: cdb fields reflect the transfer of the previous row
    vecs[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0, 4'h0};
    vecs[1]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, 2'd0, 32'h0, 4'h0};
    vecs[2]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, D2,    T2};
    vecs[3]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0, 4'h0};
    vecs[4]  = '{4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0, 32'h0, 4'h0};
    vecs[5]  = '{4'b1010, 1'b0, 4'b1000, 1'b1, 2'd1, D1,    T1};
    vecs[6]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, D3,    T3};
    vecs[7]  = '{4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0, 4'h0};
    vecs[8]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0, 32'h0, 4'h0};
    vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, D0,    T0};
    vecs[10] = '{4'b1111, 1'b0, 4'b0010, 1'b0, 2'd0, 32'h0, 4'h0};
    vecs[11] = '{4'b1111, 1'b0, 4'b0100, 1'b1, 2'd1, D1,    T1};
    vecs[12] = '{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd2, D2,    T2};
    vecs[13] = '{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd3, D3,    T3};
    vecs[14] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, D0,    T0};
    vecs[15] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0, 4'h0};
    vecs[16] = '{4'b0100, 1'b0, 4'b0100, 1'b0, 2'd0, 32'h0, 4'h0};
    vecs[17] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd2, D2,    T2};
    vecs[18] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0, 4'h0};

    // reset held with every channel requesting
    rst = 1'b0;
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    exp_q.push_back(32'h0); chk("reset rr_ready", 32'(rr_ready));
    exp_q.push_back(32'h0); chk("reset fp_ready", 32'(fp_ready));
    expect_cdb("reset rr", 1'b0, 2'd0, 32'h0, 4'h0, rr_cv, rr_src, rr_data, rr_tag);
    expect_cdb("reset fp", 1'b0, 2'd0, 32'h0, 4'h0, fp_cv, fp_src, fp_data, fp_tag);

    // round-robin fairness from reset, all four channels continuously valid
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_q.push_back(32'(4'b0001 << (k % 4))); chk("fair rr_ready", 32'(rr_ready));
      exp_q.push_back(32'h1);                   chk("fair fp_ready", 32'(fp_ready));
      if (k > 0) begin
        exp_q.push_back(32'h1);           chk("fair cdb_valid", 32'(rr_cv));
        exp_q.push_back(32'((k - 1) % 4)); chk("fair cdb_src", 32'(rr_src));
      end
      @(negedge clk);
    end
    exp_q.push_back(32'h3); chk("fair last cdb_src", 32'(rr_src));

    // fixed priority: ch0 and ch3 held valid, ch3 must never win
    req_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_q.push_back(32'h1); chk("fp ready", 32'(fp_ready));
      expect_cdb("fp", 1'b1, 2'd0, D0, T0, fp_cv, fp_src, fp_data, fp_tag);
      @(negedge clk);
    end

    // asynchronous reset mid-cycle clears the broadcast with no clock edge
    #2 rst = 1'b0;
    #1;
    expect_cdb("async rst fp", 1'b0, 2'd0, 32'h0, 4'h0, fp_cv, fp_src, fp_data, fp_tag);
    expect_cdb("async rst rr", 1'b0, 2'd0, 32'h0, 4'h0, rr_cv, rr_src, rr_data, rr_tag);
    exp_q.push_back(32'h0); chk("async rst rr_ready", 32'(rr_ready));
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;

    // directed table against the round-robin instance
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      req_valid = vecs[i].valid;
      flush     = vecs[i].flush;
      #1;
      exp_q.push_back(32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d req_ready", i), 32'(rr_ready));
      expect_cdb($sformatf("vec%0d", i), vecs[i].exp_cv, vecs[i].exp_src,
                 vecs[i].exp_data, vecs[i].exp_tag, rr_cv, rr_src, rr_data, rr_tag);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
